truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Self-contained stimulus and response stage for the 4-input combinational function block F = A(B+C+D').
- Sits directly upstream of the function block and steps A, B, C, D through all 16 combinations in index order {A,B,C,D} = 0..15.
- Samples the returned F after a programmable settle time and assembles a 16-bit truth-table result.
- Compares each sample against an expected mask and reports pass/fail, mismatch count and the first failing index.

Parameters:
- SETTLE_CYCLES, 1, cycles each vector is held before F is sampled; legal range 1..15.
- EXPECTED, 16'hFD00, expected truth table; bit i is the expected F for index i = {A,B,C,D}.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin sweep; sampled only in IDLE.
- abort  input  1  synchronous cancel of an active sweep.
- f_in  input  1  F returned by the function block.
- a_out  output  1  A stimulus (idx[3]).
- b_out  output  1  B stimulus (idx[2]).
- c_out  output  1  C stimulus (idx[1]).
- d_out  output  1  D stimulus (idx[0]).
- busy  output  1  high while the sweep is active.
- done  output  1  one-cycle pulse at sweep completion.
- pass  output  1  1 when mismatch_count == 0; valid from done, held until next start.
- result  output  16  captured F per index.
- mismatch_count  output  5  number of indices where f_in != EXPECTED[idx]; range 0..16.
- first_fail_idx  output  4  index of the first mismatch.
- fail_valid  output  1  first_fail_idx is meaningful.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - state = IDLE; idx = 0; settle counter = 0.
  - All outputs 0: a/b/c/d_out, busy, done, pass, result, mismatch_count, first_fail_idx, fail_valid.
- Stimulus outputs are registered and equal idx bits at all times.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start = 1 -> SETTLE.
  - On that edge: idx = 0, cnt = 0, result/mismatch_count/fail_valid/first_fail_idx/pass cleared, busy = 1.
- SETTLE:
  - cnt increments each cycle.
  - When cnt == SETTLE_CYCLES-1 -> SAMPLE.
- SAMPLE, on the exiting edge:
  - result[idx] <= f_in.
  - If f_in != EXPECTED[idx]: mismatch_count++; if fail_valid == 0, latch first_fail_idx = idx and set fail_valid = 1.
  - If idx == 15 -> DONE with idx held at 15.
  - Otherwise idx++, cnt = 0, -> SETTLE.
- DONE:
  - done = 1 and busy = 0 for exactly one cycle; pass = (final mismatch_count == 0), registered.
  - Next edge -> IDLE.
- Timing:
  - Each vector is presented for SETTLE_CYCLES+1 cycles.
  - done is high in the cycle beginning 16*(SETTLE_CYCLES+1) edges after the edge that accepted start (32 for the default).
- start outside IDLE is ignored; no restart and no queueing.
- abort in SETTLE or SAMPLE:
  - Next edge -> IDLE, busy = 0, no done pulse, pass stays 0.
  - result, mismatch_count, first_fail_idx, fail_valid and idx hold their partial values.
  - Any sample in progress on that edge is discarded.
- abort and start together in IDLE: start wins.
- abort in DONE is ignored.
- Reset mid-sweep forces the reset values immediately; no done pulse is generated.
- mismatch_count cannot overflow (max 16 fits in 5 bits).

Test Plan:
- Correct F model, SETTLE_CYCLES = 1, pulse start -> stimuli step 0..15 every 2 cycles; done 32 cycles after start; result = 16'hFD00, pass = 1, mismatch_count = 0, fail_valid = 0.
- F stuck at 0 -> result = 16'h0000, mismatch_count = 7, first_fail_idx = 8, fail_valid = 1, pass = 0.
- Faulty model F = A(B+C+D) -> result = 16'hFE00, mismatch_count = 2 (indices 8 and 9), first_fail_idx = 8, pass = 0.
- start re-pulsed at idx = 6, then abort at idx = 10 -> re-pulse ignored; busy falls the next cycle, no done, a/b/c/d_out hold 4'b1010, result bits above 9 remain 0.
- rst_n asserted asynchronously mid-sweep at idx = 5 -> all outputs 0 before the next clock edge; a subsequent start completes a normal sweep with pass = 1.
- SETTLE_CYCLES = 3 with the correct model -> each vector held 4 cycles, done 64 cycles after start, result = 16'hFD00.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive 4-input stimulus sweep with truth-table capture and compare
module truth_table_sweeper #(
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [15:0] EXPECTED      = 16'hFD00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        f_in,
    output logic        a_out,
    output logic        b_out,
    output logic        c_out,
    output logic        d_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] result,
    output logic [4:0]  mismatch_count,
    output logic [3:0]  first_fail_idx,
    output logic        fail_valid
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_q;
    logic [3:0]  idx_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [15:0] result_q;
    logic [4:0]  mismatch_q;
    logic [3:0]  first_fail_q;
    logic        fail_valid_q;

    logic        miss;
    logic [4:0]  mismatch_d;

    assign miss       = (f_in != EXPECTED[idx_q]);
    assign mismatch_d = mismatch_q + {4'd0, miss};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= 4'd0;
            cnt_q        <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            result_q     <= 16'd0;
            mismatch_q   <= 5'd0;
            first_fail_q <= 4'd0;
            fail_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= SETTLE;
                        idx_q        <= 4'd0;
                        cnt_q        <= 4'd0;
                        busy_q       <= 1'b1;
                        pass_q       <= 1'b0;
                        result_q     <= 16'd0;
                        mismatch_q   <= 5'd0;
                        first_fail_q <= 4'd0;
                        fail_valid_q <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= SAMPLE;
                        end
                    end
                end
                SAMPLE: begin
                    // An abort here drops the sample: partial results stay as they were.
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        result_q[idx_q] <= f_in;
                        mismatch_q      <= mismatch_d;
                        if (miss && !fail_valid_q) begin
                            first_fail_q <= idx_q;
                            fail_valid_q <= 1'b1;
                        end
                        if (idx_q == 4'd15) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (mismatch_d == 5'd0);
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            cnt_q   <= 4'd0;
                            state_q <= SETTLE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign a_out          = idx_q[3];
    assign b_out          = idx_q[2];
    assign c_out          = idx_q[1];
    assign d_out          = idx_q[0];
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign result         = result_q;
    assign mismatch_count = mismatch_q;
    assign first_fail_idx = first_fail_q;
    assign fail_valid     = fail_valid_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - scoreboard bench for truth_table_sweeper
module tb_truth_table_sweeper;

    typedef struct {
        logic [15:0] result;
        logic [4:0]  mm;
        logic [3:0]  ffi;
        logic        fv;
        logic        pass;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   f_mode = 0;

    logic        start1 = 1'b0, abort1 = 1'b0, f1;
    logic        a1, b1, c1, d1, busy1, done1, pass1, fv1;
    logic [15:0] res1;
    logic [4:0]  mm1;
    logic [3:0]  ffi1;

    logic        start3 = 1'b0, abort3 = 1'b0, f3;
    logic        a3, b3, c3, d3, busy3, done3, pass3, fv3;
    logic [15:0] res3;
    logic [4:0]  mm3;
    logic [3:0]  ffi3;

    exp_t q1[$];
    exp_t q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Function block models: 0 correct A(B+C+D'), 1 stuck at 0, 2 faulty A(B+C+D)
    function automatic logic fmod(input int mode, input logic [3:0] i);
        case (mode)
            0:       return i[3] & (i[2] | i[1] | ~i[0]);
            2:       return i[3] & (i[2] | i[1] | i[0]);
            default: return 1'b0;
        endcase
    endfunction

    assign f1 = fmod(f_mode, {a1, b1, c1, d1});
    assign f3 = fmod(f_mode, {a3, b3, c3, d3});

    truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(16'hFD00)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .f_in(f1),
        .a_out(a1), .b_out(b1), .c_out(c1), .d_out(d1),
        .busy(busy1), .done(done1), .pass(pass1), .result(res1),
        .mismatch_count(mm1), .first_fail_idx(ffi1), .fail_valid(fv1)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(3), .EXPECTED(16'hFD00)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .f_in(f3),
        .a_out(a3), .b_out(b3), .c_out(c3), .d_out(d3),
        .busy(busy3), .done(done3), .pass(pass3), .result(res3),
        .mismatch_count(mm3), .first_fail_idx(ffi3), .fail_valid(fv3)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_done(input string tag, input exp_t e, input logic [15:0] r,
                            input logic [4:0] m, input logic [3:0] f, input logic v,
                            input logic p, input logic b);
        check({tag, " result"}, 32'(r), 32'(e.result));
        check({tag, " mismatch_count"}, 32'(m), 32'(e.mm));
        check({tag, " first_fail_idx"}, 32'(f), 32'(e.ffi));
        check({tag, " fail_valid"}, 32'(v), 32'(e.fv));
        check({tag, " pass"}, 32'(p), 32'(e.pass));
        check({tag, " busy at done"}, 32'(b), 32'd0);
        check({tag, " done cycle"}, 32'(cyc), 32'(e.cyc));
    endtask

    // Monitor: pops an expectation for every done pulse
    always @(negedge clk) begin
        exp_t e;
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL dut1 unexpected done: got 1 expected 0");
            end else begin
                e = q1.pop_front();
                cmp_done("dut1", e, res1, mm1, ffi1, fv1, pass1, busy1);
            end
        end
        if (done3 === 1'b1) begin
            if (q3.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL dut3 unexpected done: got 1 expected 0");
            end else begin
                e = q3.pop_front();
                cmp_done("dut3", e, res3, mm3, ffi3, fv3, pass3, busy3);
            end
        end
    end

    task automatic sweep(input int which, input int mode, input logic [15:0] r,
                         input logic [4:0] m, input logic [3:0] f, input logic v,
                         input logic p, input logic with_abort);
        exp_t e;
        int   s;
        s = (which == 1) ? 1 : 3;
        f_mode = mode;
        @(negedge clk);
        if (which == 1) begin start1 = 1'b1; abort1 = with_abort; end
        else            begin start3 = 1'b1; abort3 = with_abort; end
        @(negedge clk);
        start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
        e.result = r; e.mm = m; e.ffi = f; e.fv = v; e.pass = p;
        e.cyc = cyc + 16 * (s + 1);
        if (which == 1) q1.push_back(e); else q3.push_back(e);
        for (int i = 0; i < 300 && (q1.size() + q3.size()) > 0; i++) @(negedge clk);
        if ((q1.size() + q3.size()) > 0) begin
            n_tests++; n_fail++;
            $display("FAIL sweep timeout dut%0d: got no done expected done", which);
            q1.delete(); q3.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_idx1(input logic [3:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if ({a1, b1, c1, d1} == v) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL wait idx %0d: got timeout expected idx reached", v);
        end
    endtask

    initial begin
        bit ok;
        int c0;
        repeat (3) @(negedge clk);
        check("reset outputs lo dut1", {a1, b1, c1, d1, busy1, done1, pass1, fv1, ffi1, mm1}, 32'd0);
        check("reset result dut1", 32'(res1), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle outputs dut3", {a3, b3, c3, d3, busy3, done3, pass3, fv3, ffi3, mm3}, 32'd0);

        sweep(1, 0, 16'hFD00, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        sweep(1, 1, 16'h0000, 5'd7, 4'd8, 1'b1, 1'b0, 1'b0);
        sweep(1, 2, 16'hFE00, 5'd2, 4'd8, 1'b1, 1'b0, 1'b1);

        // Re-pulsed start is ignored, abort at idx 10 freezes partial state
        f_mode = 0;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0; c0 = cyc;
        wait_idx1(4'd6, ok);
        start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        check("busy after re-pulse", 32'(busy1), 32'd1);
        wait_idx1(4'd10, ok);
        check("idx10 cycle", 32'(cyc), 32'(c0 + 20));
        abort1 = 1'b1;
        @(negedge clk); abort1 = 1'b0;
        check("abort busy", 32'(busy1), 32'd0);
        check("abort stimulus hold", 32'({a1, b1, c1, d1}), 32'hA);
        check("abort partial result", 32'(res1), 32'h0100);
        check("abort pass", 32'(pass1), 32'd0);
        repeat (40) @(negedge clk);
        check("abort stays idle", {busy1, a1, b1, c1, d1}, 32'hA);

        // Asynchronous reset mid-sweep
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        wait_idx1(4'd5, ok);
        #1 rst_n = 1'b0;
        #1;
        check("async reset outputs lo", {a1, b1, c1, d1, busy1, done1, pass1, fv1, ffi1, mm1}, 32'd0);
        check("async reset result", 32'(res1), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        sweep(1, 0, 16'hFD00, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0);

        sweep(3, 0, 16'hFD00, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
